// File: rtl/aes256_rkey_reader.sv
// Round-key store for an AES-256 datapath: captures the 15 expanded round keys
// once, then replays them forward (encrypt) or backward (decrypt) on demand.
//
// state | meaning
// IDLE  | nothing stored since reset; keys unusable
// LOAD  | accepting round keys 0..14 from the expansion engine
// READY | all 15 keys stored, waiting for play_start
// PLAY  | presenting one key per advance handshake
module aes256_rkey_reader (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_start,
  input  logic         key_wr_en,
  input  logic [127:0] key_wr_data,
  input  logic         play_start,
  input  logic         enc_en,
  input  logic         advance,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         f_rnd_en,
  output logic         loaded,
  output logic         busy
);

  localparam logic [3:0] LastIdx = 4'd14;

  typedef enum logic [1:0] {IDLE, LOAD, READY, PLAY} stateT;

  stateT        state, stateNext;
  logic [127:0] keyStore [15];
  logic [3:0]   wrPtr, wrPtrNext;
  logic [3:0]   rdIdx, rdIdxNext;
  logic         dirFwd, dirFwdNext;
  logic         storeWe;
  logic         lastKey, lastNext;

  always_comb begin
    lastKey = dirFwd ? (rdIdx == LastIdx) : (rdIdx == 4'd0);
  end

  always_comb begin
    stateNext  = state;
    wrPtrNext  = wrPtr;
    rdIdxNext  = rdIdx;
    dirFwdNext = dirFwd;
    storeWe    = 1'b0;
    if (load_start) begin
      stateNext = LOAD;
      wrPtrNext = 4'd0;
    end else begin
      case (state)
        LOAD: begin
          if (key_wr_en) begin
            storeWe   = 1'b1;
            wrPtrNext = wrPtr + 4'd1;
            if (wrPtr == LastIdx) stateNext = READY;
          end
        end
        READY: begin
          if (play_start) begin
            dirFwdNext = enc_en;
            rdIdxNext  = enc_en ? 4'd0 : LastIdx;
            stateNext  = PLAY;
          end
        end
        PLAY: begin
          // key_valid is always 1 in PLAY, so advance is live here
          if (advance) begin
            if (lastKey)     stateNext = READY;
            else if (dirFwd) rdIdxNext = rdIdx + 4'd1;
            else             rdIdxNext = rdIdx - 4'd1;
          end
        end
        default: ;
      endcase
    end
    lastNext = dirFwdNext ? (rdIdxNext == LastIdx) : (rdIdxNext == 4'd0);
  end

  // Key store is deliberately not reset; loaded=0 keeps stale keys from being used.
  always_ff @(posedge clk) begin
    if (!rst && storeWe) keyStore[wrPtr] <= key_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wrPtr     <= 4'd0;
      rdIdx     <= 4'd0;
      dirFwd    <= 1'b0;
      round_key <= '0;
      round_idx <= 4'd0;
      key_valid <= 1'b0;
      f_rnd_en  <= 1'b0;
      loaded    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= stateNext;
      wrPtr     <= wrPtrNext;
      rdIdx     <= rdIdxNext;
      dirFwd    <= dirFwdNext;
      key_valid <= (stateNext == PLAY);
      round_idx <= (stateNext == PLAY) ? rdIdxNext : 4'd0;
      round_key <= (stateNext == PLAY) ? keyStore[rdIdxNext] : '0;
      f_rnd_en  <= (stateNext == PLAY) && lastNext;
      loaded    <= (stateNext == READY) || (stateNext == PLAY);
      busy      <= (stateNext == LOAD) || (stateNext == PLAY);
    end
  end

endmodule

// File: tb/tb_aes256_rkey_reader.sv
// Scoreboard bench for aes256_rkey_reader: a queue-based reference model predicts
// each cycle's outputs; a negedge monitor pops and compares.
module tb_aes256_rkey_reader;

  logic         clk = 1'b0;
  logic         rst, load_start, key_wr_en, play_start, enc_en, advance;
  logic [127:0] key_wr_data;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid, f_rnd_en, loaded, busy;

  always #5 clk = ~clk;

  aes256_rkey_reader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .key_wr_en(key_wr_en),
    .key_wr_data(key_wr_data), .play_start(play_start), .enc_en(enc_en),
    .advance(advance), .round_key(round_key), .round_idx(round_idx),
    .key_valid(key_valid), .f_rnd_en(f_rnd_en), .loaded(loaded), .busy(busy)
  );

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {int cyc; logic kv; logic ld; logic bz; logic zero;} statusT;
  typedef struct {int cyc; logic [3:0] idx; logic [127:0] key; logic last;} keyT;
  statusT statusQ[$];
  keyT    keyQ[$];

  // reference model state
  logic [127:0] mStore [15];
  int           mCount = 0;
  bit           mLoading = 0;
  bit           mLoaded = 0;
  int           mPlay[$];

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cycleCnt);
  endfunction

  function automatic void modelStep(input logic r, ls, we, input logic [127:0] d,
                                    input logic ps, en, adv);
    statusT s;
    keyT    k;
    if (r) begin
      mLoading = 0;
      mLoaded  = 0;
      mPlay.delete();
    end else if (ls) begin
      mLoading = 1;
      mLoaded  = 0;
      mCount   = 0;
      mPlay.delete();
    end else if (mLoading) begin
      if (we) begin
        mStore[mCount] = d;
        mCount++;
        if (mCount == 15) begin
          mLoading = 0;
          mLoaded  = 1;
        end
      end
    end else if (mPlay.size() > 0) begin
      if (adv) mPlay.delete(0);
    end else if (mLoaded && ps) begin
      for (int i = 0; i < 15; i++) mPlay.push_back(en ? i : 14 - i);
    end
    s.cyc  = cycleCnt + 1;
    s.kv   = (mPlay.size() > 0);
    s.ld   = mLoaded;
    s.bz   = mLoading || (mPlay.size() > 0);
    s.zero = r;
    statusQ.push_back(s);
    if (mPlay.size() > 0) begin
      k.cyc  = cycleCnt + 1;
      k.idx  = 4'(mPlay[0]);
      k.key  = mStore[mPlay[0]];
      k.last = (mPlay.size() == 1);
      keyQ.push_back(k);
    end
  endfunction

  always @(negedge clk) begin : monitor
    statusT s;
    keyT    k;
    if (statusQ.size() > 0 && statusQ[0].cyc == cycleCnt) begin
      s = statusQ.pop_front();
      check("key_valid", 128'(key_valid), 128'(s.kv));
      check("loaded",    128'(loaded),    128'(s.ld));
      check("busy",      128'(busy),      128'(s.bz));
      if (s.zero) begin
        check("reset round_key", round_key, '0);
        check("reset round_idx", 128'(round_idx), '0);
        check("reset f_rnd_en",  128'(f_rnd_en),  '0);
      end
    end
    if (keyQ.size() > 0 && keyQ[0].cyc == cycleCnt) begin
      k = keyQ.pop_front();
      check("round_idx", 128'(round_idx), 128'(k.idx));
      check("round_key", round_key, k.key);
      check("f_rnd_en",  128'(f_rnd_en), 128'(k.last));
    end
  end

  function automatic logic [127:0] rndKey();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive(input logic r, ls, we, input logic [127:0] d,
                       input logic ps, en, adv);
    @(posedge clk);
    #1;
    rst = r; load_start = ls; key_wr_en = we; key_wr_data = d;
    play_start = ps; enc_en = en; advance = adv;
    modelStep(r, ls, we, d, ps, en, adv);
  endtask

  task automatic idle();
    drive(0, 0, 0, rndKey(), 0, 0, 0);
  endtask

  task automatic writeKeys(input int n, input bit patterned, input bit psToo);
    logic [3:0]   nib;
    logic [127:0] d;
    for (int i = 0; i < n; i++) begin
      nib = 4'(i);
      d   = patterned ? {32{nib}} : rndKey();
      drive(0, 0, 1, d, psToo, 1, 1);
    end
  endtask

  task automatic loadKeys(input bit patterned);
    drive(0, 1, 0, '0, 0, 0, 0);
    writeKeys(15, patterned, 0);
  endtask

  task automatic playDrain(input logic en);
    drive(0, 0, 0, '0, 1, en, 0);
    repeat (17) drive(0, 0, 0, '0, 0, 0, 1);
  endtask

  initial begin
    rst = 1; load_start = 0; key_wr_en = 0; key_wr_data = '0;
    play_start = 0; enc_en = 0; advance = 0;

    drive(1, 0, 0, '0, 0, 0, 0);
    drive(1, 0, 1, rndKey(), 1, 1, 1);
    idle();

    // reverse playback with advance held high
    loadKeys(1);
    drive(0, 0, 0, '0, 1, 0, 1);
    repeat (16) drive(0, 0, 0, '0, 0, 0, 1);
    idle();

    // forward playback, each key held two cycles
    drive(0, 0, 0, '0, 1, 1, 0);
    for (int i = 0; i < 32; i++) drive(0, 0, 0, '0, 0, 0, 1'(i % 2));
    idle();

    // partial load aborted by a new load_start; play_start ignored during LOAD
    drive(0, 1, 0, '0, 0, 0, 0);
    writeKeys(7, 0, 0);
    drive(0, 1, 0, '0, 0, 0, 0);
    drive(0, 0, 0, '0, 1, 1, 1);
    writeKeys(14, 1, 1);
    drive(0, 0, 0, '0, 1, 1, 0);
    writeKeys(1, 0, 1);
    playDrain(0);

    // load_start in PLAY at index 9
    drive(0, 0, 0, '0, 1, 1, 0);
    repeat (9) drive(0, 0, 0, '0, 0, 0, 1);
    drive(0, 1, 0, '0, 0, 0, 1);
    idle();
    writeKeys(15, 0, 0);

    // load_start and play_start together in READY
    drive(0, 1, 0, '0, 1, 1, 0);
    idle();
    writeKeys(15, 0, 0);
    playDrain(1);

    // reset in PLAY at index 5, then play_start must be ignored
    drive(0, 0, 0, '0, 1, 1, 0);
    repeat (5) drive(0, 0, 0, '0, 0, 0, 1);
    drive(1, 0, 0, '0, 1, 1, 1);
    drive(0, 0, 0, '0, 1, 1, 0);
    drive(0, 0, 0, '0, 1, 0, 1);
    loadKeys(0);
    playDrain(0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 49) == 0),
            1'($urandom_range(0, 2) != 0), rndKey(), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle();
    idle();
    repeat (3) @(negedge clk);
    check("status queue drained", 128'(statusQ.size()), '0);
    check("key queue drained",    128'(keyQ.size()),    '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
